sample_capture_writer: RTL and testbench

- Front-end writer for the peak-detection sample RAM. Accepts a streamed 8-bit sample input and waits for an optional level trigger.
- Writes DEPTH consecutive samples to addresses 0..DEPTH-1 through a RAM write port, then hands the buffer to peak_detection via start/done.
- Sits between the ADC/sample source and the dual-port RAM that peak_detection reads (10-bit address, 8-bit data).

---
 rtl/peak_pkg.sv | 18 +
 rtl/sample_capture_writer_if.sv | 26 ++
 rtl/sample_capture_writer.sv | 124 ++++++++++++
 tb/tb_sample_capture_writer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/peak_pkg.sv
// Shared types for the peak-detection capture path (sample writer, RAM wrapper, detector).
package peak_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned ADDR_W_DEF = 10;

    typedef logic [DATA_W_DEF-1:0] sample_t;
    typedef logic [ADDR_W_DEF-1:0] addr_t;

    typedef enum logic [2:0] {
        CS_IDLE,
        CS_ARMED,
        CS_CAPTURE,
        CS_FLUSH,
        CS_HANDOFF
    } cap_state_t;

endpackage

// File: rtl/sample_capture_writer_if.sv
// Sample stream, RAM write port and start/done handshake between the capture writer and its neighbours.
interface sample_capture_writer_if #(
    parameter int unsigned DATA_W = peak_pkg::DATA_W_DEF,
    parameter int unsigned ADDR_W = peak_pkg::ADDR_W_DEF
);

    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              start;
    logic              done;

    modport master (
        input  s_valid, s_data, done,
        output s_ready, mem_we, mem_addr, mem_wdata, start
    );

    modport slave (
        output s_valid, s_data, done,
        input  s_ready, mem_we, mem_addr, mem_wdata, start
    );

endinterface

// File: rtl/sample_capture_writer.sv
// Captures DEPTH samples (optionally after a level trigger) into the sample RAM,
// then requests peak_detection via start/done.
module sample_capture_writer #(
    parameter int unsigned DATA_W = peak_pkg::DATA_W_DEF,
    parameter int unsigned ADDR_W = peak_pkg::ADDR_W_DEF,
    parameter int unsigned DEPTH  = 1024
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     arm,
    input  logic                     abort,
    input  logic                     trig_en,
    input  logic [DATA_W-1:0]        trig_level,
    sample_capture_writer_if.master  bus,
    output logic                     busy,
    output logic                     overrun
);

    import peak_pkg::*;

    // One extra bit so DEPTH = 2**ADDR_W can be counted without wrapping.
    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH - 1);

    cap_state_t        state_q, state_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0] level_q, level_d;
    logic              overrun_d;
    logic              s_ready_c;
    logic              hs;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;

    assign s_ready_c   = (state_q == CS_ARMED) || (state_q == CS_CAPTURE);
    assign hs          = bus.s_valid && s_ready_c;
    assign bus.s_ready = s_ready_c;
    assign bus.start   = (state_q == CS_HANDOFF);
    assign busy        = (state_q != CS_IDLE);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        overrun_d = overrun;
        wr_en     = 1'b0;
        wr_addr   = cnt_q[ADDR_W-1:0];

        if (busy && bus.s_valid && !s_ready_c) begin
            overrun_d = 1'b1;
        end

        if (abort) begin
            state_d = CS_IDLE;
        end else begin
            unique case (state_q)
                CS_IDLE: begin
                    if (arm) begin
                        state_d   = CS_ARMED;
                        level_d   = trig_level;
                        cnt_d     = '0;
                        overrun_d = 1'b0;
                    end
                end
                CS_ARMED: begin
                    if (hs && (!trig_en || (bus.s_data >= level_q))) begin
                        wr_en   = 1'b1;
                        wr_addr = '0;
                        cnt_d   = (ADDR_W+1)'(1);
                        state_d = CS_CAPTURE;
                    end
                end
                CS_CAPTURE: begin
                    if (hs) begin
                        wr_en = 1'b1;
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == LAST_IDX) begin
                            state_d = CS_FLUSH;
                        end
                    end
                end
                CS_FLUSH: begin
                    state_d = CS_HANDOFF;
                end
                CS_HANDOFF: begin
                    if (bus.done) begin
                        state_d = CS_IDLE;
                    end
                end
                default: begin
                    state_d = CS_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= CS_IDLE;
            cnt_q   <= '0;
            level_q <= '0;
            overrun <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            overrun <= overrun_d;
        end
    end

    // Write port register stage: address/data hold their last value between writes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            bus.mem_we <= wr_en;
            if (wr_en) begin
                bus.mem_addr  <= wr_addr;
                bus.mem_wdata <= bus.s_data;
            end
        end
    end

endmodule

// File: tb/tb_sample_capture_writer.sv
// Directed bench for sample_capture_writer: free run, trigger, abort, gapped input with overrun, async reset.
module tb_sample_capture_writer;

    logic       clk = 1'b0;
    logic       reset;
    logic       arm;
    logic       abort;
    logic       trig_en;
    logic [7:0] trig_level;
    logic       busy;
    logic       overrun;

    int unsigned vectors = 0;
    int unsigned misses  = 0;
    int unsigned wr_cnt;

    sample_capture_writer_if #(.DATA_W(8), .ADDR_W(10)) bus ();

    sample_capture_writer #(
        .DATA_W(8),
        .ADDR_W(10),
        .DEPTH (1024)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .arm       (arm),
        .abort     (abort),
        .trig_en   (trig_en),
        .trig_level(trig_level),
        .bus       (bus),
        .busy      (busy),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            misses++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset       = 1'b1;
        arm         = 1'b0;
        abort       = 1'b0;
        trig_en     = 1'b0;
        trig_level  = 8'h00;
        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;
        bus.done    = 1'b0;
        tick();
        tick();
        check("rst_s_ready",   32'(bus.s_ready),   32'd0);
        check("rst_mem_we",    32'(bus.mem_we),    32'd0);
        check("rst_mem_addr",  32'(bus.mem_addr),  32'd0);
        check("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
        check("rst_start",     32'(bus.start),     32'd0);
        check("rst_busy",      32'(busy),          32'd0);
        check("rst_overrun",   32'(overrun),       32'd0);
        reset = 1'b0;
        tick();

        // Free run, no trigger, continuous valid
        arm = 1'b1;
        tick();
        arm = 1'b0;
        check("fr_busy",    32'(busy),        32'd1);
        check("fr_s_ready", 32'(bus.s_ready), 32'd1);
        for (int i = 0; i < 1024; i++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = 8'(i);
            tick();
            check("fr_we",   32'(bus.mem_we),    32'd1);
            check("fr_addr", 32'(bus.mem_addr),  32'(i));
            check("fr_data", 32'(bus.mem_wdata), 32'(i & 255));
        end
        bus.s_valid = 1'b0;
        check("fr_flush_ready", 32'(bus.s_ready), 32'd0);
        check("fr_flush_start", 32'(bus.start),   32'd0);
        tick();
        check("fr_start_rise", 32'(bus.start),  32'd1);
        check("fr_we_idle",    32'(bus.mem_we), 32'd0);
        for (int i = 0; i < 20; i++) tick();
        check("fr_start_hold", 32'(bus.start), 32'd1);
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        check("fr_start_fall", 32'(bus.start), 32'd0);
        check("fr_busy_fall",  32'(busy),      32'd0);
        check("fr_overrun",    32'(overrun),   32'd0);

        // Trigger at 0x80; the level is latched on arm, so changing it afterwards must not matter
        trig_en    = 1'b1;
        trig_level = 8'h80;
        arm        = 1'b1;
        tick();
        arm        = 1'b0;
        trig_level = 8'h00;
        for (int v = 10; v <= 120; v += 10) begin
            bus.s_valid = 1'b1;
            bus.s_data  = 8'(v);
            tick();
            check("tg_below_we", 32'(bus.mem_we), 32'd0);
        end
        check("tg_busy", 32'(busy), 32'd1);
        bus.s_data = 8'd130;
        tick();
        check("tg_first_we",   32'(bus.mem_we),    32'd1);
        check("tg_first_addr", 32'(bus.mem_addr),  32'd0);
        check("tg_first_data", 32'(bus.mem_wdata), 32'd130);
        bus.s_data = 8'd140;
        tick();
        check("tg_second_addr", 32'(bus.mem_addr),  32'd1);
        check("tg_second_data", 32'(bus.mem_wdata), 32'd140);
        bus.s_data = 8'd5;
        tick();
        check("tg_low_after_trig_we",   32'(bus.mem_we),    32'd1);
        check("tg_low_after_trig_data", 32'(bus.mem_wdata), 32'd5);
        for (int a = 3; a < 500; a++) begin
            bus.s_data = 8'(a);
            tick();
            check("tg_addr", 32'(bus.mem_addr), 32'(a));
        end

        // Abort on the handshake that would write address 500
        bus.s_data = 8'hAA;
        abort      = 1'b1;
        tick();
        abort = 1'b0;
        check("ab_busy",    32'(busy),         32'd0);
        check("ab_we",      32'(bus.mem_we),   32'd0);
        check("ab_start",   32'(bus.start),    32'd0);
        check("ab_s_ready", 32'(bus.s_ready),  32'd0);
        check("ab_addr",    32'(bus.mem_addr), 32'd499);
        tick();
        tick();
        check("ab_idle_no_overrun", 32'(overrun),   32'd0);
        check("ab_start_never",     32'(bus.start), 32'd0);

        // arm and abort together: abort wins
        arm   = 1'b1;
        abort = 1'b1;
        tick();
        arm   = 1'b0;
        abort = 1'b0;
        check("arm_abort_busy", 32'(busy), 32'd0);

        // Gapped input, arm while busy, overrun through FLUSH/HANDOFF
        trig_en     = 1'b0;
        bus.s_valid = 1'b0;
        arm         = 1'b1;
        tick();
        arm = 1'b0;
        check("gp_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 1024; i++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = 8'(i) ^ 8'h5A;
            tick();
            check("gp_we",   32'(bus.mem_we),    32'd1);
            check("gp_addr", 32'(bus.mem_addr),  32'(i));
            check("gp_data", 32'(bus.mem_wdata), 32'((i & 255) ^ 32'h5A));
            if (i == 1023) break;
            bus.s_valid = 1'b0;
            if (i == 300) arm = 1'b1;
            tick();
            arm = 1'b0;
            check("gp_gap_we", 32'(bus.mem_we), 32'd0);
        end
        check("gp_flush_ready",   32'(bus.s_ready), 32'd0);
        check("gp_flush_overrun", 32'(overrun),     32'd0);
        tick();
        check("gp_overrun_set", 32'(overrun),    32'd1);
        check("gp_start",       32'(bus.start),  32'd1);
        check("gp_no_write",    32'(bus.mem_we), 32'd0);
        tick();
        check("gp_start_hold", 32'(bus.start), 32'd1);
        bus.done = 1'b1;
        tick();
        check("gp_start_fall",    32'(bus.start), 32'd0);
        check("gp_busy_fall",     32'(busy),      32'd0);
        check("gp_overrun_stick", 32'(overrun),   32'd1);
        tick();
        check("gp_overrun_idle", 32'(overrun), 32'd1);
        check("gp_done_idle",    32'(busy),    32'd0);
        bus.done = 1'b0;
        arm      = 1'b1;
        tick();
        arm = 1'b0;
        check("gp_overrun_clear", 32'(overrun), 32'd0);
        check("gp_rearm_busy",    32'(busy),    32'd1);

        // Full capture, then asynchronous reset during HANDOFF
        wr_cnt = 0;
        for (int i = 0; i < 1024; i++) begin
            bus.s_data = 8'(i);
            tick();
            if (bus.mem_we) wr_cnt++;
        end
        bus.s_valid = 1'b0;
        check("rs_write_count", wr_cnt, 32'd1024);
        tick();
        check("rs_start_before", 32'(bus.start), 32'd1);
        #3;
        reset = 1'b1;
        #1;
        check("rs_start_async", 32'(bus.start), 32'd0);
        check("rs_busy_async",  32'(busy),      32'd0);
        check("rs_addr_async",  32'(bus.mem_addr), 32'd0);
        tick();
        #4;
        reset = 1'b0;
        tick();
        check("rs_idle_busy",  32'(busy),      32'd0);
        check("rs_idle_start", 32'(bus.start), 32'd0);
        arm = 1'b1;
        tick();
        arm         = 1'b0;
        bus.s_valid = 1'b1;
        bus.s_data  = 8'h3C;
        tick();
        bus.s_valid = 1'b0;
        check("rs_restart_addr", 32'(bus.mem_addr),  32'd0);
        check("rs_restart_data", 32'(bus.mem_wdata), 32'h3C);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end

endmodule
